trigger_scheduler: RTL and testbench
====================================

// Module: trigger_scheduler
// PURPOSE
//  Sequences the sTGC TDS capture path downstream of trigger pulse detection. Arbitrates external,
//  software and periodic trigger requests; opens one capture window per accepted trigger; hands
//  {index, source} to the data logger over a valid/ready handshake; enforces a cycle_tick-based
//  holdoff before re-arming. Provides accept/reject counters for run monitoring.
// PARAMETERS
//  WIN_W     10  width of window_len and the window counter
//  HOLD_W    4   width of holdoff_ticks and the holdoff counter
//  PERIOD_W  24  width of period and the periodic-trigger counter
//  IDX_W     8   width of trig_index
// PORTS
//  clk            in   1         system clock, the only clock
//  rst_n          in   1         asynchronous, active-low reset
//  enable         in   1         master enable; gates acceptance only
//  src_mask       in   3         [0] ext, [1] sw, [2] periodic; 1 = source allowed
//  ext_trig       in   1         one-cycle pulse from the trigger front end
//  sw_trig        in   1         one-cycle pulse from register write
//  period         in   PERIOD_W  periodic interval in clk cycles; 0 = periodic off
//  window_len     in   WIN_W     capture window length in clk cycles; 0 treated as 1
//  holdoff_ticks  in   HOLD_W    cycle_tick edges to wait after handoff; 0 = no holdoff
//  cycle_tick     in   1         one-cycle BC/frame tick
//  capture_window out  1         high for exactly max(window_len,1) cycles per accepted trigger
//  trig_valid     out  1         handoff record valid
//  trig_ready     in   1         logger accepts record
//  trig_index     out  IDX_W     index of the accepted trigger
//  trig_source    out  2         0 ext, 1 sw, 2 periodic
//  busy           out  1         high in every state except IDLE
//  accepted_cnt   out  16        accepted triggers, saturating
//  rejected_cnt   out  16        rejected request-cycles, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, periodic counter 0, trig_index 0. Asserts asynchronously;
//  releases synchronously.
//  req = {per_pulse&m[2], sw_trig&m[1], ext_trig&m[0]}. Priority: ext > sw > periodic.
//  IDLE: if enable & |req -> WINDOW; latch win_cnt = max(window_len,1), source, trig_index+1
//   (trig_index updates on accept, wraps mod 2^IDX_W; first accepted trigger has index 1).
//  WINDOW: capture_window=1; win_cnt decrements; at 1 -> HANDOFF. A request in cycle N gives
//   capture_window high from N+1 to N+max(window_len,1).
//  HANDOFF: trig_valid=1, index/source stable; on trig_ready -> HOLDOFF, or IDLE if
//   holdoff_ticks=0. trig_ready is ignored outside HANDOFF.
//  HOLDOFF: latch hold_cnt=holdoff_ticks on entry; decrement on each cycle_tick; when it reaches 0
//   -> IDLE. A tick in the entry cycle is not counted.
//  Reject: count +1 for each cycle with enable & |req that is not accepted. This covers requests
//   in non-IDLE states and the losing requests in a simultaneous IDLE cycle (+1 per cycle, not
//   per source). Requests while enable=0 are not counted.
//  enable dropping mid-sequence: the current sequence completes; there is no abort.
//  accepted_cnt, rejected_cnt: stop at 16'hFFFF. Configuration inputs are sampled only when used.
//  Periodic: cnt runs while enable & m[2] & period!=0, otherwise held at 0. per_pulse when
//   cnt>=period-1, then cnt clears. A period reduced below cnt fires on the next cycle.
// STRUCTURE
//  trigger_sched_pkg: FSM state enum {IDLE,WINDOW,HANDOFF,HOLDOFF}, SRC_EXT/SRC_SW/SRC_PER
//   codes, counter width constant CNT_W=16.
//  Sub-module trigger_period_gen: periodic counter and per_pulse output.
// TESTING
//  window_len=4, holdoff=0, ext pulse @N, ready tied 1 -> window N+1..N+4; valid @N+5, idx=1, src=0.
//  ext+sw+per same IDLE cycle -> src=0 accepted; rejected_cnt +1; accepted_cnt +1.
//  ready held 0 for 10 cycles -> valid, idx and src stable for 10 cycles; busy=1; ext pulses -> rejected +1 each.
//  holdoff=2, ticks every 8 clk -> IDLE only after the 2nd tick following handoff; ext in holdoff rejected.
//  period=5, m=3'b100, window_len=1, ready=1, holdoff=0 -> accepts as busy permits; index wraps 255->0.
//  rst_n low mid-WINDOW -> capture_window, valid and busy 0 immediately; counters and index 0.

Source files
------------

// File: rtl/trigger_sched_pkg.sv
// Shared state encoding, trigger source codes and counter helpers for the trigger scheduler.
package trigger_sched_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    HANDOFF = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [1:0] SRC_EXT = 2'd0;
  localparam logic [1:0] SRC_SW  = 2'd1;
  localparam logic [1:0] SRC_PER = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trigger_period_gen.sv
// Periodic trigger source: combinational pulse once every i_period cycles while i_run is high.
// No backpressure; the counter is held at zero whenever the source is stopped or period is 0.
module trigger_period_gen #(
  parameter int PERIOD_W = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_run,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_pulse
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                w_run;

  assign w_run   = i_run && (i_period != '0);
  // >= rather than == so a period shortened below the running count fires at once.
  assign o_pulse = w_run && (r_cnt >= (i_period - PERIOD_W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!w_run || o_pulse) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/trigger_scheduler.sv
// Arbitrates ext/sw/periodic triggers, opens one capture window per accept, hands {index, source}
// to the logger (valid held until ready) and waits a cycle_tick holdoff before re-arming.
module trigger_scheduler
  import trigger_sched_pkg::*;
#(
  parameter int WIN_W    = 10,
  parameter int HOLD_W   = 4,
  parameter int PERIOD_W = 24,
  parameter int IDX_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [2:0]          i_src_mask,
  input  logic                i_ext_trig,
  input  logic                i_sw_trig,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [WIN_W-1:0]    i_window_len,
  input  logic [HOLD_W-1:0]   i_holdoff_ticks,
  input  logic                i_cycle_tick,
  output logic                o_capture_window,
  output logic                o_trig_valid,
  input  logic                i_trig_ready,
  output logic [IDX_W-1:0]    o_trig_index,
  output logic [1:0]          o_trig_source,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_accepted_cnt,
  output logic [CNT_W-1:0]    o_rejected_cnt
);

  state_t             r_state;
  state_t             w_next;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_src;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_rej;

  logic               w_per_pulse;
  logic [2:0]         w_req;
  logic               w_any;
  logic               w_accept;
  logic               w_multi;
  logic               w_reject;
  logic [1:0]         w_src;
  logic [WIN_W-1:0]   w_win_load;
  logic               w_hold_load;
  logic               w_cap;
  logic               w_vld;

  trigger_period_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_period_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (i_enable && i_src_mask[2]),
    .i_period (i_period),
    .o_pulse  (w_per_pulse)
  );

  assign w_req      = {w_per_pulse & i_src_mask[2], i_sw_trig & i_src_mask[1], i_ext_trig & i_src_mask[0]};
  assign w_any      = i_enable && (|w_req);
  assign w_accept   = w_any && (r_state == IDLE);
  // Losers of a simultaneous IDLE cycle count as one reject for that cycle.
  assign w_multi    = (w_req & (w_req - 3'd1)) != 3'd0;
  assign w_reject   = w_any && ((r_state != IDLE) || w_multi);
  assign w_src      = w_req[0] ? SRC_EXT : (w_req[1] ? SRC_SW : SRC_PER);
  assign w_win_load = (i_window_len == '0) ? WIN_W'(1) : i_window_len;
  assign w_hold_load = (r_state == HANDOFF) && i_trig_ready;

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_vld  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = WINDOW;
      end
      WINDOW: begin
        w_cap = 1'b1;
        if (r_win_cnt == WIN_W'(1)) w_next = HANDOFF;
      end
      HANDOFF: begin
        w_vld = 1'b1;
        if (i_trig_ready) w_next = (i_holdoff_ticks == '0) ? IDLE : HOLDOFF;
      end
      HOLDOFF: begin
        if (i_cycle_tick && (r_hold_cnt == HOLD_W'(1))) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_idx      <= '0;
      r_src      <= SRC_EXT;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_win_cnt <= w_win_load;
        r_idx     <= r_idx + IDX_W'(1);
        r_src     <= w_src;
      end else if (r_state == WINDOW) begin
        r_win_cnt <= r_win_cnt - WIN_W'(1);
      end
      // Loading on the handshake cycle means a tick coincident with it is not counted.
      if (w_hold_load) begin
        r_hold_cnt <= i_holdoff_ticks;
      end else if ((r_state == HOLDOFF) && i_cycle_tick) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_rej <= '0;
    end else begin
      if (w_accept) r_acc <= sat_inc(r_acc);
      if (w_reject) r_rej <= sat_inc(r_rej);
    end
  end

  assign o_capture_window = w_cap;
  assign o_trig_valid     = w_vld;
  assign o_trig_index     = r_idx;
  assign o_trig_source    = r_src;
  assign o_busy           = (r_state != IDLE);
  assign o_accepted_cnt   = r_acc;
  assign o_rejected_cnt   = r_rej;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Bench for trigger_scheduler: directed scenarios plus random traffic against a cycle-level reference model.
module tb_trigger_scheduler;

  localparam int WIN_W    = 10;
  localparam int HOLD_W   = 4;
  localparam int PERIOD_W = 24;
  localparam int IDX_W    = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_WIN  = 1;
  localparam int PH_HAND = 2;
  localparam int PH_HOLD = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [2:0]          src_mask;
  logic                ext_trig;
  logic                sw_trig;
  logic [PERIOD_W-1:0] period;
  logic [WIN_W-1:0]    window_len;
  logic [HOLD_W-1:0]   holdoff_ticks;
  logic                cycle_tick;
  logic                trig_ready;
  logic                capture_window;
  logic                trig_valid;
  logic [IDX_W-1:0]    trig_index;
  logic [1:0]          trig_source;
  logic                busy;
  logic [15:0]         accepted_cnt;
  logic [15:0]         rejected_cnt;

  always #5 clk = ~clk;

  trigger_scheduler #(
    .WIN_W    (WIN_W),
    .HOLD_W   (HOLD_W),
    .PERIOD_W (PERIOD_W),
    .IDX_W    (IDX_W)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (enable),
    .i_src_mask       (src_mask),
    .i_ext_trig       (ext_trig),
    .i_sw_trig        (sw_trig),
    .i_period         (period),
    .i_window_len     (window_len),
    .i_holdoff_ticks  (holdoff_ticks),
    .i_cycle_tick     (cycle_tick),
    .o_capture_window (capture_window),
    .o_trig_valid     (trig_valid),
    .i_trig_ready     (trig_ready),
    .o_trig_index     (trig_index),
    .o_trig_source    (trig_source),
    .o_busy           (busy),
    .o_accepted_cnt   (accepted_cnt),
    .o_rejected_cnt   (rejected_cnt)
  );

  int    checks = 0;
  int    errors = 0;
  string g_tag  = "reset";

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase plus remaining-cycle / remaining-tick counts, stepped once per clock.
  int m_phase, m_win_left, m_hold_left, m_pcnt, m_idx, m_src, m_acc, m_rej;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_win_left = 0; m_hold_left = 0; m_pcnt = 0;
    m_idx = 0; m_src = 0; m_acc = 0; m_rej = 0;
  endtask

  task automatic model_step();
    bit run, pulse, r0, r1, r2;
    int nreq, ph;
    run   = enable && src_mask[2] && (period != 0);
    pulse = run && (m_pcnt >= int'(period) - 1);
    m_pcnt = !run ? 0 : (pulse ? 0 : m_pcnt + 1);
    r0 = ext_trig && src_mask[0];
    r1 = sw_trig && src_mask[1];
    r2 = pulse;
    nreq = int'(r0) + int'(r1) + int'(r2);
    ph = m_phase;
    if (enable && nreq > 0) begin
      if (ph == PH_IDLE) begin
        m_acc      = sat16(m_acc + 1);
        m_idx      = (m_idx + 1) % 256;
        m_src      = r0 ? 0 : (r1 ? 1 : 2);
        m_win_left = (window_len == 0) ? 1 : int'(window_len);
        m_phase    = PH_WIN;
        if (nreq > 1) m_rej = sat16(m_rej + 1);
      end else begin
        m_rej = sat16(m_rej + 1);
      end
    end
    case (ph)
      PH_WIN: begin
        m_win_left--;
        if (m_win_left == 0) m_phase = PH_HAND;
      end
      PH_HAND: begin
        if (trig_ready) begin
          if (holdoff_ticks == 0) m_phase = PH_IDLE;
          else begin
            m_hold_left = int'(holdoff_ticks);
            m_phase     = PH_HOLD;
          end
        end
      end
      PH_HOLD: begin
        if (cycle_tick) begin
          m_hold_left--;
          if (m_hold_left == 0) m_phase = PH_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_outputs();
    check_eq({g_tag, ".cap"},  32'(capture_window), 32'(m_phase == PH_WIN));
    check_eq({g_tag, ".vld"},  32'(trig_valid),     32'(m_phase == PH_HAND));
    check_eq({g_tag, ".busy"}, 32'(busy),           32'(m_phase != PH_IDLE));
    check_eq({g_tag, ".idx"},  32'(trig_index),     m_idx);
    check_eq({g_tag, ".src"},  32'(trig_source),    m_src);
    check_eq({g_tag, ".acc"},  32'(accepted_cnt),   m_acc);
    check_eq({g_tag, ".rej"},  32'(rejected_cnt),   m_rej);
  endtask

  // Called at a negedge with inputs for the coming posedge already applied.
  task automatic tick_cycle();
    model_step();
    @(negedge clk);
    compare_outputs();
    ext_trig   = 1'b0;
    sw_trig    = 1'b0;
    cycle_tick = 1'b0;
  endtask

  task automatic rand_config();
    src_mask      = 3'($urandom_range(7));
    period        = PERIOD_W'($urandom_range(12));
    window_len    = WIN_W'($urandom_range(7));
    holdoff_ticks = HOLD_W'($urandom_range(3));
  endtask

  task automatic rand_inputs();
    ext_trig   = ($urandom_range(7) == 0);
    sw_trig    = ($urandom_range(9) == 0);
    cycle_tick = ($urandom_range(5) == 0);
    trig_ready = 1'($urandom_range(1));
    enable     = ($urandom_range(15) != 0);
  endtask

  int cap_n, vld_at, base_acc, base_rej, hold_idx;

  initial begin
    rst_n = 1'b0; enable = 1'b0; src_mask = 3'b000; ext_trig = 1'b0; sw_trig = 1'b0;
    period = '0; window_len = '0; holdoff_ticks = '0; cycle_tick = 1'b0; trig_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;

    // First trigger: window N+1..N+4, valid at N+5, index 1 from ext.
    g_tag = "first";
    enable = 1'b1; src_mask = 3'b111; period = '0; window_len = WIN_W'(4);
    holdoff_ticks = '0; trig_ready = 1'b1;
    repeat (3) tick_cycle();
    ext_trig = 1'b1;
    cap_n = 0; vld_at = 0;
    for (int k = 1; k <= 8; k++) begin
      tick_cycle();
      if (capture_window) cap_n++;
      if (trig_valid && vld_at == 0) vld_at = k;
    end
    check_eq("first.cap_len", cap_n, 4);
    check_eq("first.vld_at", vld_at, 5);
    check_eq("first.idx1", 32'(trig_index), 1);
    check_eq("first.acc1", 32'(accepted_cnt), 1);

    // All three sources in one IDLE cycle: ext wins, one reject.
    g_tag = "simul";
    base_acc = m_acc; base_rej = m_rej;
    ext_trig = 1'b1; sw_trig = 1'b1; period = PERIOD_W'(1);
    tick_cycle();
    period = '0;
    check_eq("simul.src", 32'(trig_source), 0);
    check_eq("simul.acc", 32'(accepted_cnt), base_acc + 1);
    check_eq("simul.rej", 32'(rejected_cnt), base_rej + 1);
    repeat (8) tick_cycle();

    // Logger stalls for 10 cycles; record must hold and ext pulses are rejected.
    g_tag = "stall";
    window_len = WIN_W'(2); trig_ready = 1'b0; ext_trig = 1'b1;
    repeat (3) tick_cycle();
    hold_idx = m_idx; base_rej = m_rej;
    for (int k = 0; k < 10; k++) begin
      ext_trig = (k % 2 == 0);
      tick_cycle();
      check_eq("stall.vld", 32'(trig_valid), 1);
      check_eq("stall.idx", 32'(trig_index), hold_idx);
      check_eq("stall.src", 32'(trig_source), 0);
    end
    check_eq("stall.rej5", 32'(rejected_cnt), base_rej + 5);
    trig_ready = 1'b1;
    repeat (4) tick_cycle();

    // Holdoff of 2 ticks with ticks every 8 clocks and ext pulses during holdoff.
    g_tag = "holdoff";
    holdoff_ticks = HOLD_W'(2); window_len = WIN_W'(3);
    for (int k = 0; k < 80; k++) begin
      cycle_tick = (k % 8 == 7);
      ext_trig   = (k % 3 == 0);
      tick_cycle();
    end

    // Periodic-only source long enough for the index to wrap.
    g_tag = "periodic";
    src_mask = 3'b100; period = PERIOD_W'(5); window_len = WIN_W'(1); holdoff_ticks = '0;
    for (int k = 0; k < 1400; k++) begin
      cycle_tick = ((k % 8) == 0);
      tick_cycle();
    end
    check_eq("periodic.wrapped_idx", 32'(trig_index), m_idx);

    // Random traffic with configuration changes.
    g_tag = "random";
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) rand_config();
      rand_inputs();
      tick_cycle();
    end

    // Asynchronous reset in the middle of a window.
    g_tag = "prereset";
    enable = 1'b1; src_mask = 3'b001; period = '0; holdoff_ticks = '0; trig_ready = 1'b1;
    window_len = WIN_W'(6);
    for (int k = 0; k < 30; k++) begin
      cycle_tick = 1'b1;
      tick_cycle();
    end
    ext_trig = 1'b1;
    repeat (2) tick_cycle();
    check_eq("prereset.cap", 32'(capture_window), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.cap",  32'(capture_window), 0);
    check_eq("arst.vld",  32'(trig_valid), 0);
    check_eq("arst.busy", 32'(busy), 0);
    check_eq("arst.idx",  32'(trig_index), 0);
    check_eq("arst.acc",  32'(accepted_cnt), 0);
    check_eq("arst.rej",  32'(rejected_cnt), 0);
    model_reset();
    @(negedge clk);
    g_tag = "postreset";
    compare_outputs();
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      rand_inputs();
      tick_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
